// File: rtl/epp_pkg.sv
// EPP receive decoder shared definitions: default geometry, drive codes, FSM states, err bits.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package epp_pkg;

    localparam int LINE_BEATS_DEF  = 240;
    localparam int FRAME_LINES_DEF = 1080;

    // 2-bit source drive codes, eight per 16-bit data word
    localparam logic [1:0] CODE_VSS   = 2'b00;
    localparam logic [1:0] CODE_BLACK = 2'b01;
    localparam logic [1:0] CODE_WHITE = 2'b10;
    localparam logic [1:0] CODE_NONE  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_ACTIVE = 2'd2
    } epp_state_e;

    // Bit positions inside err = {seq, xoe, frame, beat}
    localparam int ERR_BEAT  = 0;
    localparam int ERR_FRAME = 1;
    localparam int ERR_XOE   = 2;
    localparam int ERR_SEQ   = 3;

endpackage

// File: rtl/epp_code_popcnt.sv
// Counts black (01) and white (10) drive codes among the eight 2-bit codes of one word.
// Latency: combinational.
// Backpressure: none.
// Ports: word_i (16b word in), n_black / n_white (0..8 counts out).
module epp_code_popcnt
    import epp_pkg::*;
(
    input  logic [15:0] word_i,
    output logic [3:0]  n_black,
    output logic [3:0]  n_white
);

    always_comb begin
        n_black = 4'd0;
        n_white = 4'd0;
        for (int i = 0; i < 8; i++) begin
            case (word_i[2*i +: 2])
                CODE_BLACK:          n_black = n_black + 4'd1;
                CODE_WHITE:          n_white = n_white + 4'd1;
                CODE_VSS, CODE_NONE: begin end
            endcase
        end
    end

endmodule

// File: rtl/epp_rx_decoder.sv
// EPP panel-bus receive decoder: recovers frame/line/beat timing and emits source words as pixels.
// Latency: epp_data word to pix_valid/pix_data is 2 cycles; line/frame pulses 2 cycles after the pin edge.
// Backpressure: none; the stream is emitted as received and the sink must always accept it.
// Ports: glb_clk/glb_rst, epp_* panel inputs, pix_* stream, line_done/frame_done pulses,
//        frame_lines/cnt_black/cnt_white per-frame results, err sticky {seq, xoe, frame, beat}.
module epp_rx_decoder
    import epp_pkg::*;
#(
    parameter int LINE_BEATS  = LINE_BEATS_DEF,
    parameter int FRAME_LINES = FRAME_LINES_DEF,
    parameter int BEAT_W      = 9,
    parameter int ROW_W       = 11,
    parameter int CNT_W       = 24
) (
    input  logic              glb_clk,
    input  logic              glb_rst,
    input  logic              epp_ckv,
    input  logic              epp_stv,
    input  logic              epp_xoe,
    input  logic              epp_xstl,
    input  logic              epp_xle,
    input  logic              epp_mode,
    input  logic [15:0]       epp_data,
    output logic              pix_valid,
    output logic [15:0]       pix_data,
    output logic [BEAT_W-1:0] pix_beat,
    output logic [ROW_W-1:0]  pix_row,
    output logic              line_done,
    output logic              frame_done,
    output logic [ROW_W-1:0]  frame_lines,
    output logic [CNT_W-1:0]  cnt_black,
    output logic [CNT_W-1:0]  cnt_white,
    output logic [3:0]        err
);

    // Input stage (s_*) and the delayed copy used for edge detection (d_*)
    logic        s_ckv_q, s_stv_q, s_xoe_q, s_xstl_q, s_xle_q, s_mode_q;
    logic [15:0] s_data_q;
    logic        d_ckv_q, d_stv_q, d_xstl_q, d_xle_q;

    epp_state_e        state_q, state_d;
    logic              pix_valid_q, pix_valid_d;
    logic [15:0]       pix_data_q, pix_data_d;
    logic [BEAT_W-1:0] pix_beat_q, pix_beat_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [ROW_W-1:0]  lines_q, lines_d;
    logic              line_done_q, line_done_d;
    logic              frame_done_q, frame_done_d;
    logic [ROW_W-1:0]  frame_lines_q, frame_lines_d;
    logic [CNT_W-1:0]  acc_b_q, acc_b_d, acc_w_q, acc_w_d;
    logic [CNT_W-1:0]  cnt_black_q, cnt_black_d, cnt_white_q, cnt_white_d;
    logic [3:0]        err_q, err_d;

    logic              stv_fall, stv_rise, xstl_fall, xle_rise, ckv_rise;
    logic [3:0]        nb, nw;
    logic [CNT_W:0]    sum_b, sum_w;
    logic [BEAT_W-1:0] beat_idx;

    assign stv_fall  =  d_stv_q  & ~s_stv_q;
    assign stv_rise  = ~d_stv_q  &  s_stv_q;
    assign xstl_fall =  d_xstl_q & ~s_xstl_q;
    assign xle_rise  = ~d_xle_q  &  s_xle_q;
    assign ckv_rise  = ~d_ckv_q  &  s_ckv_q;

    epp_code_popcnt u_popcnt (
        .word_i  (s_data_q),
        .n_black (nb),
        .n_white (nw)
    );

    // One extra bit catches the carry so the accumulators clamp instead of wrapping
    assign sum_b = {1'b0, acc_b_q} + {{(CNT_W-3){1'b0}}, nb};
    assign sum_w = {1'b0, acc_w_q} + {{(CNT_W-3){1'b0}}, nw};

    // First beat of a window restarts at 0 regardless of what the previous line left behind
    assign beat_idx = xstl_fall ? '0 : beat_q;

    always_comb begin
        state_d       = state_q;
        pix_valid_d   = 1'b0;
        pix_data_d    = pix_data_q;
        pix_beat_d    = pix_beat_q;
        beat_d        = beat_q;
        row_d         = row_q;
        lines_d       = lines_q;
        line_done_d   = 1'b0;
        frame_done_d  = 1'b0;
        frame_lines_d = frame_lines_q;
        acc_b_d       = acc_b_q;
        acc_w_d       = acc_w_q;
        cnt_black_d   = cnt_black_q;
        cnt_white_d   = cnt_white_q;
        err_d         = err_q;

        // Row advances one cycle after the line_done pulse
        if (line_done_q && row_q != '1) begin
            row_d = row_q + ROW_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (stv_fall) state_d = ST_SYNC;
            end
            ST_SYNC: begin
                if (stv_rise) begin
                    state_d = ST_ACTIVE;
                    row_d   = '0;
                    lines_d = '0;
                    beat_d  = '0;
                    acc_b_d = '0;
                    acc_w_d = '0;
                end
            end
            ST_ACTIVE: begin
                if (stv_fall) begin
                    // Frame end wins over any beat or latch seen in the same cycle
                    state_d       = ST_SYNC;
                    frame_done_d  = 1'b1;
                    frame_lines_d = lines_q;
                    cnt_black_d   = acc_b_q;
                    cnt_white_d   = acc_w_q;
                    if (32'(lines_q) != FRAME_LINES) err_d[ERR_FRAME] = 1'b1;
                    if (!s_xstl_q)                   err_d[ERR_SEQ]   = 1'b1;
                end else begin
                    if (!s_xstl_q) begin
                        pix_valid_d = 1'b1;
                        pix_data_d  = s_data_q;
                        pix_beat_d  = beat_idx;
                        beat_d      = (beat_idx == '1) ? beat_idx : beat_idx + BEAT_W'(1);
                        acc_b_d     = sum_b[CNT_W] ? '1 : sum_b[CNT_W-1:0];
                        acc_w_d     = sum_w[CNT_W] ? '1 : sum_w[CNT_W-1:0];
                        if (!s_xoe_q) err_d[ERR_XOE] = 1'b1;
                    end
                    if (xle_rise) begin
                        if (s_xstl_q) begin
                            line_done_d = 1'b1;
                            beat_d      = '0;
                            lines_d     = (lines_q == '1) ? lines_q : lines_q + ROW_W'(1);
                            if (32'(beat_q) != LINE_BEATS) err_d[ERR_BEAT] = 1'b1;
                        end else begin
                            err_d[ERR_SEQ] = 1'b1;
                        end
                    end
                end
                if (ckv_rise && !s_mode_q) err_d[ERR_SEQ] = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge glb_clk) begin
        if (glb_rst) begin
            // Input copies reset to the idle levels so reset release never fakes an edge
            s_ckv_q       <= 1'b0;
            s_stv_q       <= 1'b1;
            s_xoe_q       <= 1'b1;
            s_xstl_q      <= 1'b1;
            s_xle_q       <= 1'b0;
            s_mode_q      <= 1'b1;
            s_data_q      <= '0;
            d_ckv_q       <= 1'b0;
            d_stv_q       <= 1'b1;
            d_xstl_q      <= 1'b1;
            d_xle_q       <= 1'b0;
            state_q       <= ST_IDLE;
            pix_valid_q   <= 1'b0;
            pix_data_q    <= '0;
            pix_beat_q    <= '0;
            beat_q        <= '0;
            row_q         <= '0;
            lines_q       <= '0;
            line_done_q   <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_lines_q <= '0;
            acc_b_q       <= '0;
            acc_w_q       <= '0;
            cnt_black_q   <= '0;
            cnt_white_q   <= '0;
            err_q         <= '0;
        end else begin
            s_ckv_q       <= epp_ckv;
            s_stv_q       <= epp_stv;
            s_xoe_q       <= epp_xoe;
            s_xstl_q      <= epp_xstl;
            s_xle_q       <= epp_xle;
            s_mode_q      <= epp_mode;
            s_data_q      <= epp_data;
            d_ckv_q       <= s_ckv_q;
            d_stv_q       <= s_stv_q;
            d_xstl_q      <= s_xstl_q;
            d_xle_q       <= s_xle_q;
            state_q       <= state_d;
            pix_valid_q   <= pix_valid_d;
            pix_data_q    <= pix_data_d;
            pix_beat_q    <= pix_beat_d;
            beat_q        <= beat_d;
            row_q         <= row_d;
            lines_q       <= lines_d;
            line_done_q   <= line_done_d;
            frame_done_q  <= frame_done_d;
            frame_lines_q <= frame_lines_d;
            acc_b_q       <= acc_b_d;
            acc_w_q       <= acc_w_d;
            cnt_black_q   <= cnt_black_d;
            cnt_white_q   <= cnt_white_d;
            err_q         <= err_d;
        end
    end

    assign pix_valid   = pix_valid_q;
    assign pix_data    = pix_data_q;
    assign pix_beat    = pix_beat_q;
    assign pix_row     = row_q;
    assign line_done   = line_done_q;
    assign frame_done  = frame_done_q;
    assign frame_lines = frame_lines_q;
    assign cnt_black   = cnt_black_q;
    assign cnt_white   = cnt_white_q;
    assign err         = err_q;

endmodule
